pic_priority_resolver: RTL and testbench
========================================

# pic_priority_resolver

Priority resolution and in-service tracking stage of the 8259A-compatible PIC. Consumes the latched request vector from the interrupt request stage, applies the interrupt mask, and resolves the highest-priority pending level under fixed or rotating priority. Drives INT to the CPU, runs the two-pulse INTA handshake, and maintains the In-Service Register. Applies OCW2 EOI and rotation commands and returns a per-level clear pulse to the request stage.

## Interface
- No parameters; 8 IR levels fixed.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- Int_Req_Reg  in  8  pending requests from request stage
- Int_Mask_Reg  in  8  OCW1 mask, 1 = level masked
- Special_Mask_Mode  in  1  1 = SMM active
- Auto_EOI  in  1  ICW4 AEOI bit
- Vector_Base  in  5  ICW2 T7..T3
- Ocw2_Valid  in  1  one-cycle strobe, OCW2 written
- Ocw2_Cmd  in  3  {R, SL, EOI}
- Ocw2_Level  in  3  L2..L0
- Inta_Strobe  in  1  one-cycle pulse per INTA# falling edge
- INT  out  1  interrupt request to CPU, registered
- In_Service_Reg  out  8  ISR
- Irr_Clear  out  8  one-cycle pulse clearing the acknowledged level in the request stage
- Vector_Out  out  8  interrupt vector
- Vector_Valid  out  1  one-cycle pulse, Vector_Out valid

## Operation
- Priority pointer L (3 b): lowest-priority level; highest is L+1 mod 8. Reset L=7 (IR0 highest, IR7 lowest).
- Eligible = Int_Req_Reg & ~Int_Mask_Reg. Candidate = first eligible level scanning L+1, L+2, … mod 8.
- Normal mode: candidate wins only if its priority is strictly higher than the highest-priority set ISR bit. A set ISR bit at an equal or higher level blocks it.
- SMM: ISR bits do not block. Only a level whose own ISR bit is set is excluded.
- Rotate-in-AEOI flag RA: reset 0.
- FSM states:
  - IDLE
    - INT_next = candidate exists.
    - Inta_Strobe while INT=1 → ACK1.
      - If a candidate still exists: latch it, set its ISR bit, pulse Irr_Clear for it.
      - Else (spurious): latch level 7, no ISR set, no Irr_Clear.
    - Inta_Strobe while INT=0 is ignored.
  - ACK1
    - INT held 1; latched level frozen.
    - Inta_Strobe → IDLE; Vector_Out = {Vector_Base, level}; Vector_Valid=1.
    - If Auto_EOI=1 and not spurious: clear that ISR bit. If RA=1, also set L = level.
- OCW2 (Ocw2_Valid=1, accepted in any state):
  - 001: non-specific EOI. Clear the highest-priority set ISR bit (under current L).
  - 011: specific EOI. Clear ISR[Ocw2_Level].
  - 101: rotate on non-specific EOI. Clear as 001, then L = cleared level.
  - 111: rotate on specific EOI. Clear ISR[Ocw2_Level], then L = Ocw2_Level.
  - 110: set priority. L = Ocw2_Level.
  - 100: set RA = 1.
  - 000: set RA = 0.
  - 010: no-op.
  - EOI with ISR empty: no change, and L is unchanged even for rotate commands.
- Same-cycle events: ISR_next = (ISR & ~eoi_clear & ~aeoi_clear) | ack_set. Priority resolution uses registered (current-cycle) ISR and L.

## Timing
- Reset values: INT=0, In_Service_Reg=0, Irr_Clear=0, Vector_Out=0, Vector_Valid=0, L=7, RA=0, state IDLE.
- Reset in any state, including ACK1, overrides everything and aborts any handshake; no vector is issued.
- INT: one cycle latency from a change on Int_Req_Reg, Int_Mask_Reg, ISR, or L.
- INTA1 pulse at cycle t:
  - ISR bit and Irr_Clear visible at t+1.
  - Irr_Clear high for exactly one cycle.
- INTA2 pulse at cycle t2:
  - Vector_Out and Vector_Valid at t2+1; Vector_Out holds its value afterwards.
  - INT=0 at t2+1.
  - AEOI clear visible at t2+1; INT may re-assert at t2+2.
- Request withdrawn or masked during ACK1: no effect on the latched level.

## Test plan
- After reset, IRR=0x24 with mask 0 → INT=1. INTA1 → ISR=0x04, Irr_Clear=0x04 for 1 cycle. Base 0x08 (T7..T3 = 01000): INTA2 → Vector_Out=0x42, Vector_Valid=1 cycle, INT=0.
- ISR=0x04, then IRR bit3 raised → INT stays 0. IRR bit0 raised → INT=1. Non-specific EOI with ISR=0x05 → ISR=0x04.
- OCW2 111 with level 4 (ISR bit4 set) → ISR bit4 cleared, L=4. IRR=0x21 → serviced level 5 (vector low bits 101), not 0.
- AEOI=1, RA=1, IRR=0x08 → after INTA2, ISR=0x00 and L=3.
- INT=1 from IRR=0x02, then IRR cleared before INTA1 → spurious: ISR unchanged, no Irr_Clear, vector low bits 111.
- SMM=1, ISR=0x01, IRR=0x04 → INT=1. Reset asserted in ACK1 → all outputs return to reset values with no Vector_Valid.

Source files
------------

// File: rtl/pic_priority_resolver.sv
// 8259A-style priority resolver: masks pending requests, resolves the winning level
// under fixed/rotating priority, runs the two-pulse INTA handshake and owns the ISR.
module pic_priority_resolver (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] Int_Req_Reg,
    input  logic [7:0] Int_Mask_Reg,
    input  logic       Special_Mask_Mode,
    input  logic       Auto_EOI,
    input  logic [4:0] Vector_Base,
    input  logic       Ocw2_Valid,
    input  logic [2:0] Ocw2_Cmd,
    input  logic [2:0] Ocw2_Level,
    input  logic       Inta_Strobe,
    output logic       INT,
    output logic [7:0] In_Service_Reg,
    output logic [7:0] Irr_Clear,
    output logic [7:0] Vector_Out,
    output logic       Vector_Valid
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ACK1 = 1'b1;

    logic [0:0] state_q, state_d;
    logic       int_q, int_d;
    logic [7:0] isr_q, isr_d;
    logic [7:0] irr_clear_q, irr_clear_d;
    logic [7:0] vector_out_q, vector_out_d;
    logic       vector_valid_q, vector_valid_d;
    logic [2:0] prio_q, prio_d;
    logic       ra_q, ra_d;
    logic [2:0] level_q, level_d;
    logic       spur_q, spur_d;

    logic [7:0] eligible;
    logic       cand_found, isr_found, cand_wins;
    logic [2:0] cand_lvl, cand_rank, isr_lvl, isr_rank, idx;
    logic [7:0] ack_set, aeoi_clear, eoi_clear;

    // Scan from the level just above the lowest-priority pointer; rank 0 is highest.
    always_comb begin
        eligible = Int_Req_Reg & ~Int_Mask_Reg;
        if (Special_Mask_Mode)
            eligible = eligible & ~isr_q;
        cand_found = 1'b0;
        cand_lvl   = 3'd0;
        cand_rank  = 3'd0;
        isr_found  = 1'b0;
        isr_lvl    = 3'd0;
        isr_rank   = 3'd0;
        idx        = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = prio_q + 3'(i + 1);
            if (!cand_found && eligible[idx]) begin
                cand_found = 1'b1;
                cand_lvl   = idx;
                cand_rank  = 3'(i);
            end
            if (!isr_found && isr_q[idx]) begin
                isr_found = 1'b1;
                isr_lvl   = idx;
                isr_rank  = 3'(i);
            end
        end
        cand_wins = cand_found &&
                    (Special_Mask_Mode || !isr_found || (cand_rank < isr_rank));
    end

    always_comb begin
        state_d        = state_q;
        int_d          = int_q;
        level_d        = level_q;
        spur_d         = spur_q;
        irr_clear_d    = 8'h00;
        vector_out_d   = vector_out_q;
        vector_valid_d = 1'b0;
        prio_d         = prio_q;
        ra_d           = ra_q;
        ack_set        = 8'h00;
        aeoi_clear     = 8'h00;
        eoi_clear      = 8'h00;

        case (state_q)
            S_IDLE: begin
                int_d = cand_wins;
                if (Inta_Strobe && int_q) begin
                    state_d = S_ACK1;
                    int_d   = 1'b1;
                    if (cand_wins) begin
                        level_d     = cand_lvl;
                        spur_d      = 1'b0;
                        ack_set     = 8'd1 << cand_lvl;
                        irr_clear_d = 8'd1 << cand_lvl;
                    end else begin
                        // Request vanished before INTA1: answer with the IR7 spurious vector.
                        level_d = 3'd7;
                        spur_d  = 1'b1;
                    end
                end
            end
            default: begin
                int_d = 1'b1;
                if (Inta_Strobe) begin
                    state_d        = S_IDLE;
                    int_d          = 1'b0;
                    vector_out_d   = {Vector_Base, level_q};
                    vector_valid_d = 1'b1;
                    if (Auto_EOI && !spur_q) begin
                        aeoi_clear = 8'd1 << level_q;
                        if (ra_q)
                            prio_d = level_q;
                    end
                end
            end
        endcase

        // OCW2 is applied after AEOI rotation so an explicit command wins a same-cycle clash.
        if (Ocw2_Valid) begin
            case (Ocw2_Cmd)
                3'b001: if (isr_found) eoi_clear = 8'd1 << isr_lvl;
                3'b011: if (|isr_q) eoi_clear = 8'd1 << Ocw2_Level;
                3'b101: if (isr_found) begin
                    eoi_clear = 8'd1 << isr_lvl;
                    prio_d    = isr_lvl;
                end
                3'b111: if (|isr_q) begin
                    eoi_clear = 8'd1 << Ocw2_Level;
                    prio_d    = Ocw2_Level;
                end
                3'b110: prio_d = Ocw2_Level;
                3'b100: ra_d = 1'b1;
                3'b000: ra_d = 1'b0;
                default: ;
            endcase
        end

        isr_d = (isr_q & ~eoi_clear & ~aeoi_clear) | ack_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            int_q          <= 1'b0;
            isr_q          <= 8'h00;
            irr_clear_q    <= 8'h00;
            vector_out_q   <= 8'h00;
            vector_valid_q <= 1'b0;
            prio_q         <= 3'd7;
            ra_q           <= 1'b0;
            level_q        <= 3'd0;
            spur_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            int_q          <= int_d;
            isr_q          <= isr_d;
            irr_clear_q    <= irr_clear_d;
            vector_out_q   <= vector_out_d;
            vector_valid_q <= vector_valid_d;
            prio_q         <= prio_d;
            ra_q           <= ra_d;
            level_q        <= level_d;
            spur_q         <= spur_d;
        end
    end

    assign INT            = int_q;
    assign In_Service_Reg = isr_q;
    assign Irr_Clear      = irr_clear_q;
    assign Vector_Out     = vector_out_q;
    assign Vector_Valid   = vector_valid_q;

endmodule

// File: tb/tb_pic_priority_resolver.sv
// Scenario bench for pic_priority_resolver; issued vectors are checked against a
// queue of expected vectors filled when each INTA2 is driven.
module tb_pic_priority_resolver;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] Int_Req_Reg;
    logic [7:0] Int_Mask_Reg;
    logic       Special_Mask_Mode;
    logic       Auto_EOI;
    logic [4:0] Vector_Base;
    logic       Ocw2_Valid;
    logic [2:0] Ocw2_Cmd;
    logic [2:0] Ocw2_Level;
    logic       Inta_Strobe;
    logic       INT;
    logic [7:0] In_Service_Reg;
    logic [7:0] Irr_Clear;
    logic [7:0] Vector_Out;
    logic       Vector_Valid;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];

    pic_priority_resolver dut (
        .clk               (clk),
        .reset             (reset),
        .Int_Req_Reg       (Int_Req_Reg),
        .Int_Mask_Reg      (Int_Mask_Reg),
        .Special_Mask_Mode (Special_Mask_Mode),
        .Auto_EOI          (Auto_EOI),
        .Vector_Base       (Vector_Base),
        .Ocw2_Valid        (Ocw2_Valid),
        .Ocw2_Cmd          (Ocw2_Cmd),
        .Ocw2_Level        (Ocw2_Level),
        .Inta_Strobe       (Inta_Strobe),
        .INT               (INT),
        .In_Service_Reg    (In_Service_Reg),
        .Irr_Clear         (Irr_Clear),
        .Vector_Out        (Vector_Out),
        .Vector_Valid      (Vector_Valid)
    );

    always #5 clk = ~clk;

    // Vector scoreboard: every Vector_Valid must match the oldest expected vector.
    always @(negedge clk) begin
        if (!reset && Vector_Valid) begin
            n_checks++;
            if (exp_q.size() == 0)
                $display("FAIL sb_unexpected_vector got=%02h want=none", Vector_Out);
            else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (Vector_Out !== e) $display("FAIL sb_vector got=%02h want=%02h", Vector_Out, e);
                else n_pass++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic inta();
        Inta_Strobe = 1'b1;
        tick();
        Inta_Strobe = 1'b0;
    endtask

    task automatic ocw2(input logic [2:0] cmd, input logic [2:0] lvl);
        Ocw2_Valid = 1'b1;
        Ocw2_Cmd   = cmd;
        Ocw2_Level = lvl;
        tick();
        Ocw2_Valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_checks++;
        if ({INT, In_Service_Reg, Irr_Clear, Vector_Out, Vector_Valid} !== 26'd0)
            $display("FAIL reset_outputs got=%07h want=0",
                     {INT, In_Service_Reg, Irr_Clear, Vector_Out, Vector_Valid});
        else n_pass++;
    endtask

    task automatic test_basic_ack();
        Vector_Base  = 5'b01000;
        Int_Req_Reg  = 8'h24;
        Int_Mask_Reg = 8'h24;
        tick();
        n_checks++;
        if (INT !== 1'b0) $display("FAIL mask_blocks got=%b want=0", INT); else n_pass++;
        Int_Mask_Reg = 8'h00;
        tick();
        n_checks++;
        if (INT !== 1'b1) $display("FAIL int_assert got=%b want=1", INT); else n_pass++;
        inta();
        n_checks++;
        if (In_Service_Reg !== 8'h04) $display("FAIL inta1_isr got=%02h want=04", In_Service_Reg); else n_pass++;
        n_checks++;
        if (Irr_Clear !== 8'h04) $display("FAIL inta1_irr_clear got=%02h want=04", Irr_Clear); else n_pass++;
        Int_Req_Reg = 8'h20;
        tick();
        n_checks++;
        if (Irr_Clear !== 8'h00) $display("FAIL irr_clear_one_cycle got=%02h want=00", Irr_Clear); else n_pass++;
        n_checks++;
        if (INT !== 1'b1) $display("FAIL int_held_ack1 got=%b want=1", INT); else n_pass++;
        exp_q.push_back(8'h42);
        inta();
        n_checks++;
        if (INT !== 1'b0) $display("FAIL inta2_int_low got=%b want=0", INT); else n_pass++;
        n_checks++;
        if (Vector_Out !== 8'h42) $display("FAIL inta2_vector got=%02h want=42", Vector_Out); else n_pass++;
        tick();
        n_checks++;
        if ({Vector_Valid, Vector_Out} !== 9'h042)
            $display("FAIL vector_hold got=%03h want=042", {Vector_Valid, Vector_Out});
        else n_pass++;
        n_checks++;
        if (INT !== 1'b0) $display("FAIL lower_blocked_by_isr got=%b want=0", INT); else n_pass++;
    endtask

    task automatic test_nesting_eoi();
        Int_Req_Reg = 8'h28;
        tick();
        n_checks++;
        if (INT !== 1'b0) $display("FAIL ir3_blocked got=%b want=0", INT); else n_pass++;
        Int_Req_Reg = 8'h29;
        tick();
        n_checks++;
        if (INT !== 1'b1) $display("FAIL ir0_nests got=%b want=1", INT); else n_pass++;
        inta();
        n_checks++;
        if (In_Service_Reg !== 8'h05) $display("FAIL nest_isr got=%02h want=05", In_Service_Reg); else n_pass++;
        Int_Req_Reg = 8'h28;
        exp_q.push_back(8'h40);
        inta();
        ocw2(3'b001, 3'd0);
        n_checks++;
        if (In_Service_Reg !== 8'h04) $display("FAIL ns_eoi got=%02h want=04", In_Service_Reg); else n_pass++;
        Int_Req_Reg = 8'h00;
        ocw2(3'b011, 3'd2);
        n_checks++;
        if (In_Service_Reg !== 8'h00) $display("FAIL spec_eoi got=%02h want=00", In_Service_Reg); else n_pass++;
    endtask

    task automatic test_rotate_specific();
        Int_Req_Reg = 8'h10;
        tick();
        inta();
        Int_Req_Reg = 8'h00;
        exp_q.push_back(8'h44);
        inta();
        ocw2(3'b111, 3'd4);
        n_checks++;
        if (In_Service_Reg !== 8'h00) $display("FAIL rot_spec_isr got=%02h want=00", In_Service_Reg); else n_pass++;
        Int_Req_Reg = 8'h21;
        tick();
        inta();
        n_checks++;
        if (In_Service_Reg !== 8'h20) $display("FAIL rot_winner got=%02h want=20", In_Service_Reg); else n_pass++;
        Int_Req_Reg = 8'h00;
        exp_q.push_back(8'h45);
        inta();
        ocw2(3'b011, 3'd5);
        ocw2(3'b110, 3'd7);
    endtask

    task automatic test_aeoi_rotate();
        Auto_EOI = 1'b1;
        ocw2(3'b100, 3'd0);
        Int_Req_Reg = 8'h08;
        tick();
        inta();
        Int_Req_Reg = 8'h00;
        exp_q.push_back(8'h43);
        inta();
        n_checks++;
        if (In_Service_Reg !== 8'h00) $display("FAIL aeoi_isr got=%02h want=00", In_Service_Reg); else n_pass++;
        Int_Req_Reg = 8'h11;
        tick();
        inta();
        n_checks++;
        if (In_Service_Reg !== 8'h10) $display("FAIL aeoi_rotated_l3 got=%02h want=10", In_Service_Reg); else n_pass++;
        Int_Req_Reg = 8'h00;
        exp_q.push_back(8'h44);
        inta();
        Auto_EOI = 1'b0;
        ocw2(3'b000, 3'd0);
        ocw2(3'b110, 3'd7);
    endtask

    task automatic test_spurious();
        Int_Req_Reg = 8'h02;
        tick();
        n_checks++;
        if (INT !== 1'b1) $display("FAIL spur_int got=%b want=1", INT); else n_pass++;
        Int_Req_Reg = 8'h00;
        inta();
        n_checks++;
        if ({In_Service_Reg, Irr_Clear} !== 16'h0000)
            $display("FAIL spur_no_ack got=%04h want=0000", {In_Service_Reg, Irr_Clear});
        else n_pass++;
        exp_q.push_back(8'h47);
        inta();
        n_checks++;
        if (In_Service_Reg !== 8'h00) $display("FAIL spur_isr_after got=%02h want=00", In_Service_Reg); else n_pass++;
    endtask

    task automatic test_smm_reset_abort();
        Int_Req_Reg = 8'h01;
        tick();
        inta();
        Int_Req_Reg = 8'h00;
        exp_q.push_back(8'h40);
        inta();
        Int_Req_Reg = 8'h04;
        tick();
        tick();
        n_checks++;
        if (INT !== 1'b0) $display("FAIL normal_blocks_ir2 got=%b want=0", INT); else n_pass++;
        Special_Mask_Mode = 1'b1;
        tick();
        n_checks++;
        if (INT !== 1'b1) $display("FAIL smm_allows_ir2 got=%b want=1", INT); else n_pass++;
        inta();
        n_checks++;
        if (In_Service_Reg !== 8'h05) $display("FAIL smm_isr got=%02h want=05", In_Service_Reg); else n_pass++;
        Int_Req_Reg = 8'h00;
        reset = 1'b1;
        tick();
        n_checks++;
        if ({INT, In_Service_Reg, Irr_Clear, Vector_Out, Vector_Valid} !== 26'd0)
            $display("FAIL reset_in_ack1 got=%07h want=0",
                     {INT, In_Service_Reg, Irr_Clear, Vector_Out, Vector_Valid});
        else n_pass++;
        reset = 1'b0;
        Special_Mask_Mode = 1'b0;
        inta();
        tick();
        tick();
        n_checks++;
        if ({INT, Vector_Valid} !== 2'b00) $display("FAIL no_vector_after_abort got=%b want=00", {INT, Vector_Valid}); else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        Int_Req_Reg = 8'h00;
        Int_Mask_Reg = 8'h00;
        Special_Mask_Mode = 1'b0;
        Auto_EOI = 1'b0;
        Vector_Base = 5'd0;
        Ocw2_Valid = 1'b0;
        Ocw2_Cmd = 3'd0;
        Ocw2_Level = 3'd0;
        Inta_Strobe = 1'b0;
        test_reset();
        test_basic_ack();
        test_nesting_eoi();
        test_rotate_specific();
        test_aeoi_rotate();
        test_spurious();
        test_smm_reset_abort();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL sb_vectors_missing got=%0d want=0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
